// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmit types, message length and nibble-to-ASCII helper
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_type;

  localparam int MSG_LEN = 10;

  // Uppercase hex digit: 0-9 -> "0".."9", 10-15 -> "A".."F"
  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 byte serializer; ready marks the last cycle of each stop bit
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CW = $clog2(DIV);

  tx_state_type  tx_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [9:0]    frame;
  logic          bit_end;

  assign bit_end = (baud_cnt == CW'(DIV - 1));
  // Sampling valid here lets the next byte start with no idle gap
  assign ready   = (tx_state == STOP) && bit_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      frame    <= '1;
      tx       <= 1'b1;
    end else if (tx_state == IDLE) begin
      if (valid) begin
        tx_state <= START;
        frame    <= {1'b1, data, 1'b0};
        baud_cnt <= '0;
        tx       <= 1'b0;
      end
    end else begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      if (bit_end) begin
        case (tx_state)
          START: begin
            tx_state <= DATA;
            bit_idx  <= '0;
            frame    <= {1'b1, frame[9:1]};
            tx       <= frame[1];
          end
          DATA: begin
            frame <= {1'b1, frame[9:1]};
            tx    <= frame[1];
            if (bit_idx == 3'd7) tx_state <= STOP;
            else                 bit_idx  <= bit_idx + 1'b1;
          end
          STOP: begin
            if (valid) begin
              tx_state <= START;
              frame    <= {1'b1, data, 1'b0};
              tx       <= 1'b0;
            end else begin
              tx_state <= IDLE;
            end
          end
          default: tx_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/score_uart_reporter.sv
// rtl/score_uart_reporter.sv - formats "Sss ssss\r\n" from tetris state/score and sends it over UART
module score_uart_reporter
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter bit AUTO_SEND = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  state,
  input  logic [15:0] score,
  input  logic        send,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam int DIV = CLK_HZ / BAUD;

  logic [3:0]  byte_idx;
  logic [7:0]  state_q;
  logic [15:0] score_q;
  logic [15:0] sent_score;
  logic        pending;
  logic        idle, trigger, accept, last_byte;
  logic        byte_valid, byte_ready;
  logic [7:0]  byte_data;

  // The done cycle is deliberately not idle, so a send landing there becomes pending
  assign idle       = !busy && !done;
  assign trigger    = send || pending || (AUTO_SEND && (score != sent_score));
  assign accept     = idle && trigger;
  assign last_byte  = (byte_idx == 4'(MSG_LEN - 1));
  assign byte_valid = accept || (busy && !last_byte);

  // byte_data is the byte that follows byte_idx (or "S" at accept)
  always_comb begin
    byte_data = 8'h53;
    if (!accept) begin
      case (byte_idx)
        4'd0:    byte_data = hex2ascii(state_q[7:4]);
        4'd1:    byte_data = hex2ascii(state_q[3:0]);
        4'd2:    byte_data = 8'h20;
        4'd3:    byte_data = hex2ascii(score_q[15:12]);
        4'd4:    byte_data = hex2ascii(score_q[11:8]);
        4'd5:    byte_data = hex2ascii(score_q[7:4]);
        4'd6:    byte_data = hex2ascii(score_q[3:0]);
        4'd7:    byte_data = 8'h0D;
        4'd8:    byte_data = 8'h0A;
        default: byte_data = 8'h53;
      endcase
    end
  end

  uart_byte_tx #(.DIV(DIV)) u_byte_tx (
    .clk   (clk),
    .reset (reset),
    .valid (byte_valid),
    .data  (byte_data),
    .ready (byte_ready),
    .tx    (uart_tx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      pending    <= 1'b0;
      byte_idx   <= '0;
      state_q    <= '0;
      score_q    <= '0;
      sent_score <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        busy       <= 1'b1;
        byte_idx   <= '0;
        state_q    <= state;
        score_q    <= score;
        sent_score <= score;
        pending    <= 1'b0;
      end else begin
        if (send && !idle) pending <= 1'b1;
        if (byte_ready) begin
          if (last_byte) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_score_uart_reporter.sv
// tb/tb_score_uart_reporter.sv - directed bench with UART decoder and expected-byte scoreboard
module tb_score_uart_reporter;

  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  state = 8'h00;
  logic [15:0] score = 16'h0000;
  logic        send = 1'b0;
  logic        uart_tx, busy, done;
  logic [7:0]  state_d = 8'h00;
  logic [15:0] score_d = 16'h0000;
  logic        send_d = 1'b0;
  logic        uart_tx_d, busy_d, done_d;

  int checks = 0;
  int errors = 0;
  int done_total = 0;
  logic [7:0] exp_q[$];

  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;

  score_uart_reporter #(.CLK_HZ(8), .BAUD(1), .AUTO_SEND(1'b1)) dut (
    .clk(clk), .reset(reset), .state(state), .score(score), .send(send),
    .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  score_uart_reporter #(.CLK_HZ(50_000_000), .BAUD(115200), .AUTO_SEND(1'b1)) dut_def (
    .clk(clk), .reset(reset), .state(state_d), .score(score_d), .send(send_d),
    .uart_tx(uart_tx_d), .busy(busy_d), .done(done_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_msg(input logic [7:0] st, input logic [15:0] sc);
    string hx;
    hx = "0123456789ABCDEF";
    exp_q.push_back(8'h53);
    exp_q.push_back(hx[st[7:4]]);
    exp_q.push_back(hx[st[3:0]]);
    exp_q.push_back(8'h20);
    exp_q.push_back(hx[sc[15:12]]);
    exp_q.push_back(hx[sc[11:8]]);
    exp_q.push_back(hx[sc[7:4]]);
    exp_q.push_back(hx[sc[3:0]]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  always @(negedge clk) if (done === 1'b1) done_total++;

  // Mid-bit sampling decoder; a frame is dropped if busy falls inside it (reset)
  always @(negedge clk) begin
    if (rx_active) begin
      if (busy !== 1'b1) begin
        rx_active = 1'b0;
      end else begin
        rx_cnt++;
        for (int i = 0; i < 8; i++)
          if (rx_cnt == DIV + DIV / 2 + i * DIV) rx_byte[i] = uart_tx;
        if (rx_cnt == 9 * DIV + DIV / 2) begin
          check("rx_stop_bit", uart_tx, 1);
          check("rx_expected_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("rx_byte", rx_byte, exp_q.pop_front());
          rx_active = 1'b0;
        end
      end
    end else if (uart_tx === 1'b0 && busy === 1'b1) begin
      rx_active = 1'b1;
      rx_cnt = 0;
    end
  end

  initial begin
    int n, bad, d0, gap, low;
    logic [7:0] lit [10];
    lit = '{8'h53, 8'h30, 8'h33, 8'h20, 8'h31, 8'h32, 8'h41, 8'h46, 8'h0D, 8'h0A};

    repeat (3) @(negedge clk);
    check("reset_tx", uart_tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_tx_def", uart_tx_d, 1);
    reset = 1'b0;

    // Idle with score 0: no auto report
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    // Single send of state 03 score 12AF
    state = 8'h03;
    score = 16'h12AF;
    send = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(lit[i]);
    d0 = done_total;
    @(negedge clk);
    send = 1'b0;
    check("single_busy_rise", busy, 1);
    check("single_start_bit", uart_tx, 0);
    measure_busy(n);
    check("single_busy_len", n, 800);
    check("single_done", done, 1);
    @(negedge clk);
    check("single_done_pulse", done, 0);
    check("single_done_count", done_total - d0, 1);
    check("single_rx_left", exp_q.size(), 0);

    // Auto send, snapshot held while score changes mid-message
    repeat (5) @(negedge clk);
    score = 16'h0005;
    push_msg(8'h03, 16'h0005);
    @(negedge clk);
    check("auto_busy_rise", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      if (n == 400) begin
        score = 16'h0006;
        push_msg(8'h03, 16'h0006);
      end
      n++;
      @(negedge clk);
    end
    check("auto_first_len", n, 800);
    check("auto_first_done", done, 1);
    gap = 0;
    while (busy !== 1'b1 && gap < 20) begin
      gap++;
      @(negedge clk);
    end
    check("auto_gap", gap, 2);
    measure_busy(n);
    check("auto_second_len", n, 800);
    check("auto_rx_left", exp_q.size(), 0);

    // Coalescing: 3 sends in flight plus one in the done cycle -> one extra message
    repeat (5) @(negedge clk);
    d0 = done_total;
    send = 1'b1;
    push_msg(8'h03, 16'h0006);
    push_msg(8'h03, 16'h0006);
    @(negedge clk);
    send = 1'b0;
    check("coal_busy_rise", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      send = (n == 100 || n == 300 || n == 500);
      n++;
      @(negedge clk);
    end
    send = 1'b0;
    check("coal_first_len", n, 800);
    check("coal_done", done, 1);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("coal_idle_cycle", busy, 0);
    @(negedge clk);
    check("coal_followup_rise", busy, 1);
    measure_busy(n);
    check("coal_followup_len", n, 800);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    check("coal_no_third", bad, 0);
    check("coal_done_count", done_total - d0, 2);
    check("coal_rx_left", exp_q.size(), 0);

    // Reset during byte 4 data bits
    score = 16'h0007;
    push_msg(8'h03, 16'h0007);
    @(negedge clk);
    check("rst_busy_rise", busy, 1);
    repeat (340) @(negedge clk);
    check("rst_bytes_seen", exp_q.size(), 6);
    d0 = done_total;
    reset = 1'b1;
    @(negedge clk);
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    exp_q.delete();
    push_msg(8'h03, 16'h0007);
    @(negedge clk);
    check("rst_restart_busy", busy, 1);
    check("rst_restart_start", uart_tx, 0);
    measure_busy(n);
    check("rst_restart_len", n, 800);
    @(negedge clk);
    check("rst_done_count", done_total - d0, 1);
    check("rst_rx_left", exp_q.size(), 0);

    // Default rate instance
    send_d = 1'b1;
    @(negedge clk);
    send_d = 1'b0;
    check("def_busy_rise", busy_d, 1);
    n = 0;
    low = 0;
    while (busy_d === 1'b1 && n < 50000) begin
      if (uart_tx_d === 1'b0 && n == low) low++;
      n++;
      @(negedge clk);
    end
    check("def_start_width", low, 434);
    check("def_msg_len", n, 43400);
    check("def_done", done_d, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
